audio_pwm_out: RTL and testbench
================================

# audio_pwm_out

Output stage directly downstream of the sample-playback block. Takes signed 8-bit samples at the 12 kHz sample strobe, applies a 4-bit volume and a click-free soft-mute ramp, and drives a 1-bit PWM (or, optionally, sigma-delta) line to the board's audio low-pass filter and jack.

## Interface
- `RAMP_LOG2`, default 6: ramp length is 2^RAMP_LOG2 samples; legal range 1..8.
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  reset: asynchronous and active-low.
- `sample_in`  input  8  signed two's-complement sample, valid when strobed.
- `sample_valid_in`  input  1  single-cycle strobe, nominally 12 kHz. Also advances the ramp.
- `enable_in`  input  1  level signal: 1 = play (unmute), 0 = mute.
- `volume_in`  input  4  unsigned gain 0..15, in units of 1/16.
- `pwm_out`  output  1  registered audio bitstream.
- `active_out`  output  1  high only in state ACTIVE.

## Operation
- Reset (`rst_in`=0, async) sets the following:
  - hold, scaled and ramped registers = 0; gain = 0; state = MUTED.
  - duty_pending = duty_active = 128; PWM counter = 0.
  - `pwm_out`=0 and `active_out`=0.
- **Pipeline**, with each stage clocked once per strobe:
  - S1: hold <= `sample_in` when `sample_valid_in`.
  - S2: scaled = (hold × volume) >>> 4, as a 12-bit signed product with arithmetic shift. Result range −120..119. `volume_in` is sampled at S2.
  - S3: ramped = (scaled × gain) >>> RAMP_LOG2, signed. Then duty_pending <= ramped + 128, i.e. ramped with the MSB inverted, giving 8-bit unsigned. Silence = 128.
- **Ramp FSM** (states MUTED, RAMP_UP, ACTIVE, RAMP_DOWN). It evaluates `enable_in` every cycle; gain changes only on `sample_valid_in`.
  - MUTED: gain=0. If `enable_in`=1, go to RAMP_UP.
  - RAMP_UP: gain+1 per strobe. When gain reaches 2^RAMP_LOG2, go to ACTIVE. If `enable_in`=0, go to RAMP_DOWN immediately; gain is kept, with no jump.
  - ACTIVE: gain = 2^RAMP_LOG2. If `enable_in`=0, go to RAMP_DOWN.
  - RAMP_DOWN: gain−1 per strobe. When gain reaches 0, go to MUTED. If `enable_in`=1, go to RAMP_UP, with gain kept.
  - Gain saturates: it never exceeds 2^RAMP_LOG2 and never goes below 0. The gain register is RAMP_LOG2+1 bits wide.
- **PWM**:
  - 8-bit free-running counter, incremented every clock, wrapping 255 to 0.
  - When the counter equals 255, duty_active <= duty_pending.
  - `pwm_out` <= (counter < duty_active).
  - Duty 0 gives constant 0. Duty 255 gives 255/256 high. Duty 128 gives 50 %.

## Timing
- Strobe in cycle t: hold valid at t+1, scaled at t+2, duty_pending at t+3. Fixed latency of 3 cycles.
- duty_pending takes effect at the next counter wrap, so the extra delay is 1..256 cycles. It is never applied mid-period. The PWM period is 256 cycles, which is well above 12 kHz at a 100 MHz clock.
- If duty_pending updates in the same cycle as counter==255, the old duty_pending is loaded. The new value loads at the following wrap.
- Gain updates in the cycle after the strobe, so S3 of that strobe uses the pre-update gain.
- `active_out` is registered. It rises in the cycle after gain reaches full scale.
- Strobes closer than 3 cycles apart are out of spec. Each stage still takes the latest value.

## Configuration
- `AUDIO_SIGMA_DELTA_EN` defined:
  - The PWM counter is replaced by a first-order delta-sigma modulator: 9-bit acc <= {1'b0, acc[7:0]} + duty_pending each cycle.
  - `pwm_out` <= acc[8] (the carry).
  - duty_pending is used directly, with no period alignment.
  - acc resets to 0.
- Not defined: PWM as described above. The modulator logic is absent.

## Test plan
- Reset, then hold `enable_in`=0 and strobe sample_in=+127 with volume 15. Expect state stays MUTED, `pwm_out` high exactly 128 of every 256 cycles, and `active_out`=0.
- enable=1, volume=15, constant sample +127, RAMP_LOG2=6. After 64 strobes, `active_out`=1 and duty_pending=247 (119+128), so `pwm_out` is high 247/256.
- volume=8, sample −128, ACTIVE. Expect scaled=−64, duty_pending=64, and `pwm_out` high 64 cycles per period.
- In RAMP_UP at gain=20, drop `enable_in`. Expect RAMP_DOWN. After 20 strobes gain=0, then MUTED, then duty 128. No gain value above 20 is seen.
- Update duty_pending in the cycle where counter==255. Expect the old duty for that period and the new duty from the next wrap.
- With `AUDIO_SIGMA_DELTA_EN` defined and duty_pending=64, expect the ones density over 1024 cycles to be exactly 256. Assert reset mid-stream and expect `pwm_out`=0 immediately, asynchronously.

Source files
------------

// File: rtl/audio_pwm_out.sv
// ---------------------------------------------------------------------------
// audio_pwm_out
//   Audio output stage. Signed 8-bit samples arrive on a single-cycle strobe,
//   are scaled by a 4-bit volume (1/16 steps) and a soft-mute gain ramp, then
//   converted to an offset-binary duty value driving a 1-bit bitstream.
//
//   Optional build macro: AUDIO_SIGMA_DELTA_EN
//     undefined : 256-cycle PWM, duty latched at each counter wrap
//     defined   : first-order delta-sigma modulator, duty used directly
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous, active-low reset
//   sample_in        signed sample, captured when sample_valid_in is high
//   sample_valid_in  single-cycle sample strobe; also paces the gain ramp
//   enable_in        1 = play (ramp up), 0 = mute (ramp down)
//   volume_in        unsigned gain 0..15 in units of 1/16
//   pwm_out          registered audio bitstream
//   active_out       registered, high only while the ramp FSM is in ACTIVE
//
// Handshake: sample_valid_in is a one-cycle qualifier with no back-pressure;
// the block always accepts the sample presented with the strobe.
// ---------------------------------------------------------------------------
module audio_pwm_out #(
   parameter int RAMP_LOG2 = 6
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] sample_in,
   input  logic       sample_valid_in,
   input  logic       enable_in,
   input  logic [3:0] volume_in,
   output logic       pwm_out,
   output logic       active_out
);

   localparam int GW = RAMP_LOG2 + 1;          // gain register width
   localparam int PW = 8 + GW + 1;             // S3 product width
   localparam logic [GW-1:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};

   typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       gain_q, gain_d;
   logic                active_q, active_d;

   logic signed [7:0]   hold_q;
   logic [GW-1:0]       gain_snap_q;
   logic                v1_q, v2_q;
   logic signed [7:0]   scaled_q, scaled_d;
   logic [7:0]          duty_pending_q, duty_pending_d;
   logic                pwm_q;

   logic signed [11:0]  prod2;
   logic signed [PW-1:0] prod3;
   logic signed [7:0]   ramped;

   // S2: 12-bit signed product; volume is zero-extended so it stays positive.
   assign prod2    = 12'(hold_q) * 12'($signed({1'b0, volume_in}));
   assign scaled_d = 8'(prod2 >>> 4);

   // S3: gain is the value snapshotted with the sample, i.e. pre-update.
   assign prod3          = PW'(scaled_q) * PW'($signed({1'b0, gain_snap_q}));
   assign ramped         = 8'(prod3 >>> RAMP_LOG2);
   assign duty_pending_d = {~ramped[7], ramped[6:0]};

   // Sample pipeline: each stage fires one cycle after the previous one.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         hold_q         <= '0;
         gain_snap_q    <= '0;
         v1_q           <= 1'b0;
         v2_q           <= 1'b0;
         scaled_q       <= '0;
         duty_pending_q <= 8'd128;
      end else begin
         v1_q <= sample_valid_in;
         v2_q <= v1_q;
         if (sample_valid_in) begin
            hold_q      <= sample_in;
            gain_snap_q <= gain_q;
         end
         if (v1_q) scaled_q       <= scaled_d;
         if (v2_q) duty_pending_q <= duty_pending_d;
      end
   end

   // Ramp FSM: direction follows enable_in every cycle, gain moves per strobe.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      case (state_q)
         MUTED: begin
            gain_d = '0;
            if (enable_in) state_d = RAMP_UP;
         end
         RAMP_UP: begin
            if (!enable_in) begin
               state_d = RAMP_DOWN;
            end else if (gain_q >= GAIN_FULL) begin
               gain_d  = GAIN_FULL;
               state_d = ACTIVE;
            end else if (sample_valid_in) begin
               gain_d = gain_q + GW'(1);
               if (gain_q + GW'(1) == GAIN_FULL) state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            gain_d = GAIN_FULL;
            if (!enable_in) state_d = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (enable_in) begin
               state_d = RAMP_UP;
            end else if (gain_q == '0) begin
               state_d = MUTED;
            end else if (sample_valid_in) begin
               gain_d = gain_q - GW'(1);
               if (gain_q == GW'(1)) state_d = MUTED;
            end
         end
         default: begin
            state_d = MUTED;
            gain_d  = '0;
         end
      endcase
      active_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= MUTED;
         gain_q   <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gain_q   <= gain_d;
         active_q <= active_d;
      end
   end

`ifdef AUDIO_SIGMA_DELTA_EN
   // First-order delta-sigma: the carry out of an 8-bit accumulator.
   logic [8:0] acc_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         acc_q <= {1'b0, acc_q[7:0]} + {1'b0, duty_pending_q};
         pwm_q <= acc_q[8];
      end
   end
`else
   // PWM: duty only changes at the wrap so no period is ever split.
   logic [7:0] cnt_q;
   logic [7:0] duty_active_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q         <= '0;
         duty_active_q <= 8'd128;
         pwm_q         <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 8'd1;
         if (cnt_q == 8'hFF) duty_active_q <= duty_pending_q;
         pwm_q <= (cnt_q < duty_active_q);
      end
   end
`endif

   assign pwm_out    = pwm_q;
   assign active_out = active_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// ---------------------------------------------------------------------------
// tb_audio_pwm_out
//   Directed bench for audio_pwm_out (RAMP_LOG2 = 6). Expected duty values
//   are hand-computed: (sample * volume) >>> 4, then * gain >>> 6, plus 128.
// ---------------------------------------------------------------------------
module tb_audio_pwm_out;

   logic       clk_in;
   logic       rst_in;
   logic [7:0] sample_in;
   logic       sample_valid_in;
   logic       enable_in;
   logic [3:0] volume_in;
   logic       pwm_out;
   logic       active_out;

   int n_checks;
   int n_fails;
   int highs;
   int max_gain;
   bit track_max;

   audio_pwm_out #(.RAMP_LOG2(6)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .sample_in       (sample_in),
      .sample_valid_in (sample_valid_in),
      .enable_in       (enable_in),
      .volume_in       (volume_in),
      .pwm_out         (pwm_out),
      .active_out      (active_out)
   );

   // ---------------- clock / reset ----------------
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (track_max && int'(dut.gain_q) > max_gain) max_gain = int'(dut.gain_q);
   end

   // ---------------- drivers ----------------
   task automatic do_strobe(input logic [7:0] s);
      @(negedge clk_in);
      sample_in       = s;
      sample_valid_in = 1'b1;
      @(negedge clk_in);
      sample_valid_in = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic strobe_n(input int n, input logic [7:0] s);
      for (int i = 0; i < n; i++) do_strobe(s);
   endtask

   // Counts high samples over n consecutive negedges, starting at the current one.
   task automatic measure(input int n, output int h);
      h = 0;
      for (int i = 0; i < n; i++) begin
         if (pwm_out) h++;
         @(negedge clk_in);
      end
   endtask

`ifndef AUDIO_SIGMA_DELTA_EN
   task automatic wait_cnt(input logic [7:0] v, input string tag);
      int k;
      k = 0;
      while (dut.cnt_q != v && k < 300) begin
         @(negedge clk_in);
         k++;
      end
      check_eq(tag, (k < 300) ? 1 : 0, 1);
   endtask
`endif

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fails  = 0;
      max_gain = 0;
      track_max = 1'b0;
      rst_in = 1'b0;
      sample_in = '0;
      sample_valid_in = 1'b0;
      enable_in = 1'b0;
      volume_in = 4'd15;

      repeat (3) @(negedge clk_in);
      check_eq("reset_pwm", int'(pwm_out), 0);
      check_eq("reset_active", int'(active_out), 0);
      rst_in = 1'b1;

      // Muted: full-scale sample still gives silence (duty 128).
      strobe_n(4, 8'sd127);
      repeat (300) @(negedge clk_in);
      measure(256, highs);
      check_eq("muted_duty", highs, 128);
      check_eq("muted_active", int'(active_out), 0);

      // Ramp up: 64 strobes to full gain.
      enable_in = 1'b1;
      repeat (2) @(negedge clk_in);
      strobe_n(63, 8'sd127);
      check_eq("ramp63_active", int'(active_out), 0);
      check_eq("ramp63_gain", int'(dut.gain_q), 63);
      do_strobe(8'sd127);
      check_eq("ramp64_active", int'(active_out), 1);
      strobe_n(2, 8'sd127);
      repeat (300) @(negedge clk_in);
      measure(256, highs);
      check_eq("full_duty_247", highs, 247);

      // volume 8, sample -128: scaled -64, duty 64.
      volume_in = 4'd8;
      strobe_n(2, 8'h80);
      repeat (300) @(negedge clk_in);
      measure(256, highs);
      check_eq("neg_duty_64", highs, 64);
      check_eq("neg_active", int'(active_out), 1);

`ifdef AUDIO_SIGMA_DELTA_EN
      measure(1024, highs);
      check_eq("sd_density_256", highs, 256);
      volume_in = 4'd15;
      strobe_n(2, 8'sd127);
`else
      // Duty update lands on the same edge as counter 255: old duty first.
      wait_cnt(8'd253, "wait_cnt253");
      volume_in       = 4'd15;
      sample_in       = 8'sd127;
      sample_valid_in = 1'b1;
      @(negedge clk_in);
      sample_valid_in = 1'b0;
      wait_cnt(8'd1, "wait_cnt1");
      measure(256, highs);
      check_eq("wrap_old_duty", highs, 64);
      measure(256, highs);
      check_eq("wrap_new_duty", highs, 247);
`endif

      // Full ramp down to MUTED.
      enable_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check_eq("down_active", int'(active_out), 0);
      strobe_n(64, 8'sd127);
      check_eq("down_gain0", int'(dut.gain_q), 0);

      // Partial ramp up to 20, then reverse.
      enable_in = 1'b1;
      repeat (2) @(negedge clk_in);
      strobe_n(20, 8'sd127);
      check_eq("up_gain20", int'(dut.gain_q), 20);
      check_eq("up20_active", int'(active_out), 0);
      enable_in = 1'b0;
      track_max = 1'b1;
      repeat (2) @(negedge clk_in);
      check_eq("reverse_gain_kept", int'(dut.gain_q), 20);
      strobe_n(20, 8'sd127);
      track_max = 1'b0;
      check_eq("reverse_gain0", int'(dut.gain_q), 0);
      check_eq("reverse_max_gain", max_gain, 20);
      strobe_n(2, 8'sd127);
      repeat (300) @(negedge clk_in);
      measure(256, highs);
      check_eq("remuted_duty", highs, 128);

      // Asynchronous reset while the output is high.
      begin
         int k;
         k = 0;
         while (!pwm_out && k < 300) begin
            @(negedge clk_in);
            k++;
         end
         check_eq("wait_pwm_high", int'(pwm_out), 1);
      end
      #2 rst_in = 1'b0;
      #1;
      check_eq("async_rst_pwm", int'(pwm_out), 0);
      check_eq("async_rst_active", int'(active_out), 0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
